// File: rtl/mole_round_ctrl.sv
// mole_round_ctrl: whack-a-mole game sequencer.
// Each round lights one pseudo-random mole, runs the external countdown timer
// and scores the round from the player's hit or from timer expiry. Every
// output is a flop; the output next-state values are derived from the FSM
// next state so outputs always agree with the state they belong to.
module mole_round_ctrl #(
    parameter int unsigned NUM_MOLES  = 4,
    parameter int unsigned ROUNDS     = 10,
    parameter int unsigned SCORE_W    = 8,
    parameter int unsigned GAP_CYCLES = 2,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [NUM_MOLES-1:0] hit_i,
    input  logic                 timer_done_i,
    output logic                 timer_rst_n_o,
    output logic [NUM_MOLES-1:0] mole_o,
    output logic [SCORE_W-1:0]   score_o,
    output logic [SCORE_W-1:0]   miss_o,
    output logic [7:0]           round_o,
    output logic                 busy_o,
    output logic                 game_over_o
);

    localparam int unsigned      IDX_W    = $clog2(NUM_MOLES);
    localparam int unsigned      GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SAT    = '1;
    localparam logic [7:0]       ROUNDS_L = 8'(ROUNDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UP,
        S_GAP,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             lfsr_q, lfsr_d;
    logic [IDX_W-1:0]       prev_idx_q, prev_idx_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic [NUM_MOLES-1:0]   mole_q, mole_d;
    logic [SCORE_W-1:0]     score_q, score_d;
    logic [SCORE_W-1:0]     miss_q, miss_d;
    logic [7:0]             round_q, round_d;
    logic                   busy_q, busy_d;
    logic                   game_over_q, game_over_d;
    logic                   timer_rst_n_q, timer_rst_n_d;

    logic [IDX_W-1:0]       raw_idx;
    logic [IDX_W-1:0]       pick_idx;
    logic                   hit_ok;
    logic                   hit_any;
    logic                   load_mole;

    // Free-running 8-bit Fibonacci LFSR, taps 8,6,5,4
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // Mole choice: low LFSR bits, bumped by one when it would repeat the last mole
    always_comb begin
        raw_idx  = lfsr_q[IDX_W-1:0];
        pick_idx = (raw_idx == prev_idx_q) ? raw_idx + IDX_W'(1) : raw_idx;
        hit_ok   = |(hit_i & mole_q);
        hit_any  = |hit_i;
    end

    // Next-state, scoring and registered-output decode
    always_comb begin
        state_d     = state_q;
        prev_idx_d  = prev_idx_q;
        gap_cnt_d   = gap_cnt_q;
        mole_d      = mole_q;
        score_d     = score_q;
        miss_d      = miss_q;
        round_d     = round_q;
        load_mole   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d   = S_LOAD;
                    score_d   = '0;
                    miss_d    = '0;
                    round_d   = '0;
                    load_mole = 1'b1;
                end
            end
            S_LOAD: begin
                state_d = S_UP;
            end
            S_UP: begin
                // A correct bit wins over wrong bits and over a same-cycle expiry
                if (hit_ok) begin
                    score_d = (score_q == SAT) ? score_q : score_q + SCORE_W'(1);
                end else if (hit_any || timer_done_i) begin
                    miss_d  = (miss_q == SAT) ? miss_q : miss_q + SCORE_W'(1);
                end
                if (hit_any || timer_done_i) begin
                    state_d   = S_GAP;
                    round_d   = round_q + 8'd1;
                    gap_cnt_d = '0;
                    mole_d    = '0;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    if (round_q == ROUNDS_L) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_LOAD;
                        load_mole = 1'b1;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                mole_d  = '0;
            end
        endcase

        // The mole lights on the edge into LOAD so it is visible one cycle after start
        if (load_mole) begin
            mole_d     = NUM_MOLES'(1) << pick_idx;
            prev_idx_d = pick_idx;
        end

        busy_d        = (state_d == S_LOAD) || (state_d == S_UP) || (state_d == S_GAP);
        timer_rst_n_d = (state_d == S_UP);
        game_over_d   = (state_d == S_DONE);
    end

    // State, LFSR, counters and output flops
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q       <= S_IDLE;
            lfsr_q        <= LFSR_SEED;
            prev_idx_q    <= '0;
            gap_cnt_q     <= '0;
            mole_q        <= '0;
            score_q       <= '0;
            miss_q        <= '0;
            round_q       <= '0;
            busy_q        <= 1'b0;
            game_over_q   <= 1'b0;
            timer_rst_n_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            prev_idx_q    <= prev_idx_d;
            gap_cnt_q     <= gap_cnt_d;
            mole_q        <= mole_d;
            score_q       <= score_d;
            miss_q        <= miss_d;
            round_q       <= round_d;
            busy_q        <= busy_d;
            game_over_q   <= game_over_d;
            timer_rst_n_q <= timer_rst_n_d;
        end
    end

    assign timer_rst_n_o = timer_rst_n_q;
    assign mole_o        = mole_q;
    assign score_o       = score_q;
    assign miss_o        = miss_q;
    assign round_o       = round_q;
    assign busy_o        = busy_q;
    assign game_over_o   = game_over_q;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Directed bench for mole_round_ctrl: a default game instance driven round by
// round against a countdown-timer and LFSR reference, plus a small-score,
// eight-mole instance run for many auto-hit games.
module tb_mole_round_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // instance 1: default parameters
    logic       start1;
    logic [3:0] hit1;
    logic       tdone1, trst1, busy1, go1;
    logic [3:0] mole1;
    logic [7:0] score1, miss1, round1;
    logic       td_force;

    // instance 2: SCORE_W=2, ROUNDS=6, 8 moles, auto-hit
    logic       start2;
    logic [7:0] hit2;
    logic       trst2, busy2, go2;
    logic [7:0] mole2;
    logic [1:0] score2, miss2;
    logic [7:0] round2;

    mole_round_ctrl u_dut1 (
        .clk_i(clk), .reset_i(rst_n), .start_i(start1), .hit_i(hit1),
        .timer_done_i(tdone1), .timer_rst_n_o(trst1), .mole_o(mole1),
        .score_o(score1), .miss_o(miss1), .round_o(round1),
        .busy_o(busy1), .game_over_o(go1)
    );

    mole_round_ctrl #(
        .NUM_MOLES(8), .ROUNDS(6), .SCORE_W(2), .GAP_CYCLES(1), .LFSR_SEED(8'h3C)
    ) u_dut2 (
        .clk_i(clk), .reset_i(rst_n), .start_i(start2), .hit_i(hit2),
        .timer_done_i(1'b0), .timer_rst_n_o(trst2), .mole_o(mole2),
        .score_o(score2), .miss_o(miss2), .round_o(round2),
        .busy_o(busy2), .game_over_o(go2)
    );

    // instance 2 player hits the lit mole on its first UP cycle
    assign hit2 = trst2 ? mole2 : 8'h00;

    // countdown timer: reload 5 while held, count to 0, then flag expiry
    logic [2:0] tcnt;
    logic       tmr_done;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= 3'd5; tmr_done <= 1'b0;
        end else if (!trst1) begin
            tcnt <= 3'd5; tmr_done <= 1'b0;
        end else if (tcnt == 3'd0) begin
            tmr_done <= 1'b1;
        end else begin
            tcnt <= tcnt - 3'd1;
        end
    end
    assign tdone1 = tmr_done | td_force;

    // reference LFSR for instance 1; lfsr_last is the value seen before the latest edge
    logic [7:0] lfsr_m, lfsr_last;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_m <= 8'hA5; lfsr_last <= 8'hA5;
        end else begin
            lfsr_last <= lfsr_m;
            lfsr_m    <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] prev_m;
    logic [3:0] exp_m;
    int         exp_score, exp_miss, exp_round;

    // called right after the edge into LOAD
    task automatic check_load();
        logic [1:0] idx;
        logic [3:0] old;
        old = exp_m;
        idx = lfsr_last[1:0];
        if (idx == prev_m) idx = idx + 2'd1;
        prev_m = idx;
        exp_m  = 4'b0001 << idx;
        chk("mole_load", mole1, exp_m);
        chk("mole_differs", (mole1 != old) ? 1 : 0, 1);
        chk("load_trst", trst1, 0);
    endtask

    // kind: 0 correct hit, 1 timeout, 2 hit with expiry, 3 wrong hit
    task automatic play_round(input int kind, input bit poke_start);
        int n;
        tick();
        chk("up_trst", trst1, 1);
        if (poke_start) begin
            start1 = 1'b1; tick(); start1 = 1'b0;
            chk("poke_busy", busy1, 1);
            chk("poke_mole", mole1, exp_m);
            chk("poke_round", round1, exp_round);
            chk("poke_trst", trst1, 1);
        end
        case (kind)
            0: begin hit1 = exp_m; tick(); hit1 = 4'h0; end
            2: begin hit1 = exp_m; td_force = 1'b1; tick(); hit1 = 4'h0; td_force = 1'b0; end
            3: begin hit1 = ~exp_m; tick(); hit1 = 4'h0; end
            default: begin
                n = 0;
                while (mole1 != 4'h0 && n < 20) begin tick(); n++; end
                chk("timeout_lat", n, poke_start ? 6 : 7);
            end
        endcase
        if (kind == 0 || kind == 2) exp_score++; else exp_miss++;
        exp_round++;
        chk("score", score1, exp_score);
        chk("miss", miss1, exp_miss);
        chk("round", round1, exp_round);
        chk("gap_mole", mole1, 0);
        chk("gap_trst", trst1, 0);
        tick();
        chk("gap2_mole", mole1, 0);
        tick();
        if (exp_round == 10) begin
            chk("done_go", go1, 1);
            chk("done_busy", busy1, 0);
            chk("done_trst", trst1, 0);
            chk("done_mole", mole1, 0);
        end else begin
            check_load();
        end
    endtask

    // instance 2 mole monitor: each new lit mole must be one-hot and differ from the last
    int         rounds2 = 0, oh_viol = 0, rep_viol = 0;
    logic [7:0] last_m2 = 8'h00, samp_m2 = 8'h00;
    always @(posedge clk) begin
        #1;
        if (rst_n && mole2 != 8'h00 && samp_m2 == 8'h00) begin
            rounds2++;
            if (!$onehot(mole2)) oh_viol++;
            if (mole2 == last_m2) rep_viol++;
            last_m2 = mole2;
        end
        samp_m2 = mole2;
    end

    task automatic run_game2();
        int n;
        start2 = 1'b1; tick(); start2 = 1'b0;
        n = 0;
        while (!go2 && n < 40) begin tick(); n++; end
        chk("g2_end", go2, 1);
        chk("g2_score", score2, 3);
    endtask

    initial begin
        int games;
        rst_n = 1'b0; start1 = 1'b0; hit1 = 4'h0; td_force = 1'b0; start2 = 1'b0;
        prev_m = 2'd0; exp_m = 4'h0;
        exp_score = 0; exp_miss = 0; exp_round = 0;
        repeat (3) tick();
        chk("rst_mole", mole1, 0);
        chk("rst_score", score1, 0);
        chk("rst_miss", miss1, 0);
        chk("rst_round", round1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_go", go1, 0);
        chk("rst_trst", trst1, 0);
        rst_n = 1'b1;
        tick();

        // game A: hit, timeout, hit+expiry, wrong hit
        start1 = 1'b1; tick(); start1 = 1'b0;
        chk("start_busy", busy1, 1);
        check_load();
        play_round(0, 1'b0);
        play_round(1, 1'b0);
        play_round(2, 1'b0);
        play_round(3, 1'b0);

        // asynchronous reset in the middle of UP
        tick();
        chk("pre_rst_trst", trst1, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_mole", mole1, 0);
        chk("arst_busy", busy1, 0);
        chk("arst_trst", trst1, 0);
        chk("arst_score", score1, 0);
        chk("arst_round", round1, 0);
        prev_m = 2'd0; exp_m = 4'h0;
        #2 rst_n = 1'b1;
        tick();

        // game B: ten rounds alternating hit/timeout, start poked during an UP
        exp_score = 0; exp_miss = 0; exp_round = 0;
        start1 = 1'b1; tick(); start1 = 1'b0;
        check_load();
        for (int i = 0; i < 10; i++) play_round(i % 2, i == 3);
        chk("end_score", score1, 5);
        chk("end_miss", miss1, 5);
        chk("end_round", round1, 10);
        repeat (3) tick();
        chk("hold_score", score1, 5);
        chk("hold_round", round1, 10);
        chk("hold_go", go1, 1);
        start1 = 1'b1; tick(); start1 = 1'b0;
        chk("restart_score", score1, 0);
        chk("restart_miss", miss1, 0);
        chk("restart_round", round1, 0);
        chk("restart_go", go1, 0);
        chk("restart_busy", busy1, 1);
        check_load();

        // instance 2: saturation and mole selection over many games
        run_game2();
        chk("g2_miss", miss2, 0);
        chk("g2_round", round2, 6);
        repeat (4) tick();
        chk("g2_hold", score2, 3);
        games = 0;
        while (rounds2 < 1000 && games < 300) begin
            repeat ($urandom_range(0, 7)) tick();
            run_game2();
            games++;
        end
        chk("g2_rounds", (rounds2 >= 1000) ? 1 : 0, 1);
        chk("g2_onehot", oh_viol, 0);
        chk("g2_norepeat", rep_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
